// File: rtl/mesi_snoop_responder_pkg.sv
// rtl/mesi_snoop_responder_pkg.sv - MESI state and snoop command types plus the snoop next-state function
package mesi_snoop_responder_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_state_t;

    typedef enum logic [1:0] {
        SNP_NONE = 2'd0,
        SNP_READ = 2'd1,
        SNP_EXCL = 2'd2
    } snoop_cmd_t;

    // A remote read leaves any valid copy shared; a remote exclusive or invalidate drops it.
    function automatic mesi_state_t snoop_next_state(input mesi_state_t cur, input snoop_cmd_t cmd);
        mesi_state_t nxt;
        nxt = cur;
        case (cmd)
            SNP_READ: nxt = (cur == MESI_I) ? MESI_I : MESI_S;
            SNP_EXCL: nxt = MESI_I;
            default:  nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mesi_snoop_responder_if.sv
// rtl/mesi_snoop_responder_if.sv - snoop, local update, writeback and invalidate signals of the responder
interface mesi_snoop_responder_if
    import mesi_snoop_responder_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int ADDR_W    = 32
);
    localparam int IDX_W = $clog2(NUM_LINES);

    logic              snoop_read;
    logic              snoop_read_excl;
    logic              snoop_invalidate;
    logic [ADDR_W-1:0] snoop_addr;
    logic              snoop_ready;
    logic              snoop_done;
    logic              snoop_hit;
    logic              snoop_shared;

    logic              local_upd_valid;
    logic [ADDR_W-1:0] local_upd_addr;
    mesi_state_t       local_upd_state;
    logic              local_upd_ready;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_ready;

    logic              inv_valid;
    logic [IDX_W-1:0]  inv_index;

    modport master (
        output snoop_read, snoop_read_excl, snoop_invalidate, snoop_addr,
        input  snoop_ready, snoop_done, snoop_hit, snoop_shared,
        output local_upd_valid, local_upd_addr, local_upd_state,
        input  local_upd_ready,
        input  wb_valid, wb_addr,
        output wb_ready,
        input  inv_valid, inv_index
    );

    modport slave (
        input  snoop_read, snoop_read_excl, snoop_invalidate, snoop_addr,
        output snoop_ready, snoop_done, snoop_hit, snoop_shared,
        input  local_upd_valid, local_upd_addr, local_upd_state,
        output local_upd_ready,
        output wb_valid, wb_addr,
        input  wb_ready,
        output inv_valid, inv_index
    );

endinterface

// File: rtl/mesi_snoop_responder_tag_array.sv
// rtl/mesi_snoop_responder_tag_array.sv - direct-mapped tag and MESI state storage, one sync read and one write port
module mesi_snoop_responder_tag_array
    import mesi_snoop_responder_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int TAG_W     = 24,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag,
    output mesi_state_t      rd_state,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  mesi_state_t      wr_state
);

    logic [TAG_W-1:0] tags   [NUM_LINES];
    mesi_state_t      states [NUM_LINES];

    // Reset empties every line; otherwise one write and one registered read per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tags[i]   <= '0;
                states[i] <= MESI_I;
            end
            rd_tag   <= '0;
            rd_state <= MESI_I;
        end else begin
            if (wr_en) begin
                tags[wr_idx]   <= wr_tag;
                states[wr_idx] <= wr_state;
            end
            if (rd_en) begin
                rd_tag   <= tags[rd_idx];
                rd_state <= states[rd_idx];
            end
        end
    end

endmodule

// File: rtl/mesi_snoop_responder.sv
// rtl/mesi_snoop_responder.sv - MESI snoop responder top; optional SNOOP_STATS_EN adds hit/writeback/invalidate counters
module mesi_snoop_responder
    import mesi_snoop_responder_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int ADDR_W     = 32,
    parameter int LINE_OFF_W = 4
) (
    input  logic clk,
    input  logic rst,
    mesi_snoop_responder_if.slave bus
`ifdef SNOOP_STATS_EN
    ,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_wbs,
    output logic [15:0] stat_invs
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - LINE_OFF_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_WB_REQ = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    logic [1:0]        state;
    snoop_cmd_t        cmd_in;
    snoop_cmd_t        cmd_q;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic              hit_q;
    mesi_state_t       next_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic              done_q;
    logic              hit_out_q;
    logic              shared_q;
    logic              inv_q;
    logic [IDX_W-1:0]  inv_idx_q;

    logic              any_snoop;
    logic              accept;
    logic              local_fire;
    logic              lookup_hit;
    logic [TAG_W-1:0]  arr_tag;
    mesi_state_t       arr_state;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    mesi_state_t       wr_state;

    wire unused_offsets = ^{bus.snoop_addr[LINE_OFF_W-1:0], bus.local_upd_addr[LINE_OFF_W-1:0]};

    assign any_snoop  = bus.snoop_read | bus.snoop_read_excl | bus.snoop_invalidate;
    assign accept     = (state == ST_IDLE) && any_snoop;
    assign local_fire = bus.local_upd_valid && bus.local_upd_ready;
    assign lookup_hit = (arr_state != MESI_I) && (arr_tag == tag_q);

    assign bus.snoop_ready     = (state == ST_IDLE);
    assign bus.local_upd_ready = (state == ST_IDLE) && !any_snoop;
    assign bus.wb_valid        = (state == ST_WB_REQ);
    assign bus.wb_addr         = wb_addr_q;
    assign bus.snoop_done      = done_q;
    assign bus.snoop_hit       = hit_out_q;
    assign bus.snoop_shared    = shared_q;
    assign bus.inv_valid       = inv_q;
    assign bus.inv_index       = inv_idx_q;

    // Exclusive and invalidate both remove the local copy, so either outranks a plain read.
    always_comb begin
        cmd_in = SNP_NONE;
        if (bus.snoop_read_excl || bus.snoop_invalidate) begin
            cmd_in = SNP_EXCL;
        end else if (bus.snoop_read) begin
            cmd_in = SNP_READ;
        end
    end

    // Snoop UPDATE and a local update can never coincide: local updates are only taken in IDLE.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = idx_q;
        wr_tag   = tag_q;
        wr_state = next_q;
        if ((state == ST_UPDATE) && hit_q) begin
            wr_en = 1'b1;
        end else if (local_fire) begin
            wr_en    = 1'b1;
            wr_idx   = bus.local_upd_addr[LINE_OFF_W +: IDX_W];
            wr_tag   = bus.local_upd_addr[ADDR_W-1 -: TAG_W];
            wr_state = bus.local_upd_state;
        end
    end

    mesi_snoop_responder_tag_array #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W),
        .IDX_W     (IDX_W)
    ) u_tag_array (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (accept),
        .rd_idx   (bus.snoop_addr[LINE_OFF_W +: IDX_W]),
        .rd_tag   (arr_tag),
        .rd_state (arr_state),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .wr_state (wr_state)
    );

    // Snoop sequencer: capture, compare, optional writeback, then commit and report.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cmd_q     <= SNP_NONE;
            tag_q     <= '0;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            next_q    <= MESI_I;
            wb_addr_q <= '0;
            done_q    <= 1'b0;
            hit_out_q <= 1'b0;
            shared_q  <= 1'b0;
            inv_q     <= 1'b0;
            inv_idx_q <= '0;
        end else begin
            done_q    <= 1'b0;
            hit_out_q <= 1'b0;
            shared_q  <= 1'b0;
            inv_q     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_q <= cmd_in;
                        tag_q <= bus.snoop_addr[ADDR_W-1 -: TAG_W];
                        idx_q <= bus.snoop_addr[LINE_OFF_W +: IDX_W];
                        state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    hit_q  <= lookup_hit;
                    next_q <= snoop_next_state(arr_state, cmd_q);
                    if (lookup_hit && (arr_state == MESI_M)) begin
                        wb_addr_q <= {tag_q, idx_q, {LINE_OFF_W{1'b0}}};
                        state     <= ST_WB_REQ;
                    end else begin
                        state <= ST_UPDATE;
                    end
                end
                ST_WB_REQ: begin
                    if (bus.wb_ready) begin
                        state <= ST_UPDATE;
                    end
                end
                default: begin
                    done_q    <= 1'b1;
                    hit_out_q <= hit_q;
                    shared_q  <= hit_q && (next_q == MESI_S);
                    inv_q     <= hit_q && (next_q == MESI_I);
                    inv_idx_q <= idx_q;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SNOOP_STATS_EN
    // Saturating event counters for snoop hits, completed writebacks and invalidations.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_hits <= '0;
            stat_wbs  <= '0;
            stat_invs <= '0;
        end else begin
            if (done_q && hit_out_q && (stat_hits != 16'hFFFF)) begin
                stat_hits <= stat_hits + 16'd1;
            end
            if (bus.wb_valid && bus.wb_ready && (stat_wbs != 16'hFFFF)) begin
                stat_wbs <= stat_wbs + 16'd1;
            end
            if (inv_q && (stat_invs != 16'hFFFF)) begin
                stat_invs <= stat_invs + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mesi_snoop_responder.sv
// tb/tb_mesi_snoop_responder.sv - self-checking bench for mesi_snoop_responder against a line-state model
module tb_mesi_snoop_responder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [23:0] mtag [16];
    int          mst  [16];

    mesi_snoop_responder_if #(.NUM_LINES(16), .ADDR_W(32)) bus ();

`ifdef SNOOP_STATS_EN
    logic [15:0] stat_hits, stat_wbs, stat_invs;
`endif

    mesi_snoop_responder #(
        .NUM_LINES  (16),
        .ADDR_W     (32),
        .LINE_OFF_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SNOOP_STATS_EN
        ,
        .stat_hits (stat_hits),
        .stat_wbs  (stat_wbs),
        .stat_invs (stat_invs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mtag[i] = '0;
            mst[i]  = 0;
        end
    endtask

    task automatic local_upd(input logic [31:0] a, input int st);
        int n;
        n = 0;
        while (!bus.local_upd_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.local_upd_ready) begin
            failures++;
            $display("FAIL local_ready_timeout got=%0b want=1", bus.local_upd_ready);
        end
        bus.local_upd_valid = 1'b1;
        bus.local_upd_addr  = a;
        bus.local_upd_state = mesi_snoop_responder_pkg::mesi_state_t'(st[1:0]);
        tick();
        bus.local_upd_valid = 1'b0;
        mtag[a[7:4]] = a[31:8];
        mst[a[7:4]]  = st;
    endtask

    task automatic do_snoop(input logic [31:0] a, input logic r, input logic x, input logic iv,
                            input int stall, input string nm);
        int  idx;
        bit  excl, ehit, ewb, eshared, einv;
        int  elat, lat, n;
        bit  got_done, seen_wb, ghit, gshared, ginv;
        logic [3:0] ginv_idx;
        idx     = int'(a[7:4]);
        excl    = x || iv;
        ehit    = (mst[idx] != 0) && (mtag[idx] == a[31:8]);
        ewb     = ehit && (mst[idx] == 3);
        eshared = ehit && !excl;
        einv    = ehit && excl;
        elat    = ewb ? (3 + stall) : 2;
        n = 0;
        while (!bus.snoop_ready && n < 20) begin
            tick();
            n++;
        end
        bus.snoop_read       = r;
        bus.snoop_read_excl  = x;
        bus.snoop_invalidate = iv;
        bus.snoop_addr       = a;
        tick();
        bus.snoop_read       = 1'b0;
        bus.snoop_read_excl  = 1'b0;
        bus.snoop_invalidate = 1'b0;
        lat = 0; got_done = 0; seen_wb = 0; n = 0;
        ghit = 0; gshared = 0; ginv = 0; ginv_idx = '0;
        while (!got_done && lat < 40) begin
            if (bus.wb_valid) begin
                n++;
                if (!seen_wb) begin
                    checks++;
                    if (bus.wb_addr !== {a[31:4], 4'h0}) begin
                        failures++;
                        $display("FAIL %s wb_addr got=%h want=%h", nm, bus.wb_addr, {a[31:4], 4'h0});
                    end
                end
                seen_wb = 1;
                bus.wb_ready = (n > stall);
            end
            tick();
            lat++;
            bus.wb_ready = 1'b0;
            if (bus.snoop_done) begin
                got_done = 1;
                ghit     = bus.snoop_hit;
                gshared  = bus.snoop_shared;
                ginv     = bus.inv_valid;
                ginv_idx = bus.inv_index;
            end
        end
        checks++;
        if (!got_done || lat != elat) begin
            failures++;
            $display("FAIL %s latency got=%0d done=%0b want=%0d", nm, lat, got_done, elat);
        end
        checks++;
        if (seen_wb != ewb) begin
            failures++;
            $display("FAIL %s wb_request got=%0b want=%0b", nm, seen_wb, ewb);
        end
        checks++;
        if (ghit != ehit || gshared != eshared) begin
            failures++;
            $display("FAIL %s hit_shared got=%0b/%0b want=%0b/%0b", nm, ghit, gshared, ehit, eshared);
        end
        checks++;
        if (ginv != einv || (einv && ginv_idx != a[7:4])) begin
            failures++;
            $display("FAIL %s inv got=%0b idx=%0d want=%0b idx=%0d", nm, ginv, ginv_idx, einv, a[7:4]);
        end
        tick();
        checks++;
        if (bus.snoop_done !== 1'b0 || bus.inv_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s pulse_width done=%0b inv=%0b want=0/0", nm, bus.snoop_done, bus.inv_valid);
        end
        if (ehit) mst[idx] = excl ? 0 : 1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.snoop_ready !== 1'b1 || bus.snoop_done !== 1'b0 || bus.wb_valid !== 1'b0 ||
            bus.inv_valid !== 1'b0 || bus.wb_addr !== 32'h0 || bus.snoop_hit !== 1'b0 ||
            bus.snoop_shared !== 1'b0 || bus.local_upd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs ready=%0b done=%0b wb=%0b inv=%0b wb_addr=%h want=1/0/0/0/0",
                     bus.snoop_ready, bus.snoop_done, bus.wb_valid, bus.inv_valid, bus.wb_addr);
        end
        rst = 1'b1;
        tick();
        model_clear();
        do_snoop(32'h0000_0000, 1, 0, 0, 0, "reset_tag0_miss");
    endtask

    task automatic test_read_hit();
        local_upd(32'h100, 2);
        do_snoop(32'h100, 1, 0, 0, 0, "read_e_to_s");
        do_snoop(32'h104, 1, 0, 0, 0, "read_s_stays_s");
    endtask

    task automatic test_tag_miss();
        do_snoop(32'h1100, 1, 0, 0, 0, "diff_tag_miss");
        do_snoop(32'h100, 1, 0, 0, 0, "line_still_s");
    endtask

    task automatic test_writeback();
        local_upd(32'h200, 3);
        do_snoop(32'h208, 0, 1, 0, 3, "excl_m_wb");
        do_snoop(32'h200, 1, 0, 0, 0, "after_wb_miss");
        local_upd(32'h2F0, 3);
        do_snoop(32'h2F0, 1, 0, 0, 0, "read_m_wb");
        do_snoop(32'h2F0, 0, 0, 1, 0, "inv_s_to_i");
    endtask

    task automatic test_reset_mid_wb();
        bit saw_done;
        local_upd(32'h200, 3);
        bus.snoop_read = 1'b1;
        bus.snoop_addr = 32'h200;
        tick();
        bus.snoop_read = 1'b0;
        tick();
        checks++;
        if (bus.wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL midwb_valid got=%0b want=1", bus.wb_valid);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL midwb_drop got=%0b want=0", bus.wb_valid);
        end
        rst = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.snoop_done) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL midwb_no_done got=1 want=0");
        end
        model_clear();
        do_snoop(32'h200, 1, 0, 0, 0, "midwb_cleared");
    endtask

    task automatic test_priority();
        local_upd(32'h300, 2);
        do_snoop(32'h300, 1, 1, 0, 0, "read_and_excl");
        do_snoop(32'h300, 1, 0, 0, 0, "prio_line_gone");
    endtask

    task automatic test_local_vs_snoop();
        bit accepted, done_before;
        local_upd(32'h140, 1);
        bus.snoop_read      = 1'b1;
        bus.snoop_addr      = 32'h140;
        bus.local_upd_valid = 1'b1;
        bus.local_upd_addr  = 32'h540;
        bus.local_upd_state = mesi_snoop_responder_pkg::MESI_M;
        #1;
        checks++;
        if (bus.local_upd_ready !== 1'b0) begin
            failures++;
            $display("FAIL collide_ready got=%0b want=0", bus.local_upd_ready);
        end
        tick();
        bus.snoop_read = 1'b0;
        accepted = 0;
        done_before = 0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            if (bus.snoop_done) done_before = 1;
            if (bus.local_upd_ready) accepted = 1;
            tick();
        end
        bus.local_upd_valid = 1'b0;
        checks++;
        if (!accepted || !done_before) begin
            failures++;
            $display("FAIL collide_order accepted=%0b done_first=%0b want=1/1", accepted, done_before);
        end
        mtag[4] = 24'h5;
        mst[4]  = 3;
        do_snoop(32'h540, 0, 1, 0, 1, "collide_local_applied");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int op, c;
        for (int k = 0; k < 50; k++) begin
            a  = {22'($urandom_range(0, 2)), 2'b00, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            a  = {a[31:8] >> 2, a[7:0]};
            op = $urandom_range(0, 4);
            if (op < 2) begin
                local_upd(a, $urandom_range(0, 3));
            end else begin
                c = $urandom_range(1, 7);
                do_snoop(a, c[0], c[1], c[2], $urandom_range(0, 3), "random");
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        bus.snoop_read = 1'b0;
        bus.snoop_read_excl = 1'b0;
        bus.snoop_invalidate = 1'b0;
        bus.snoop_addr = '0;
        bus.local_upd_valid = 1'b0;
        bus.local_upd_addr = '0;
        bus.local_upd_state = mesi_snoop_responder_pkg::MESI_I;
        bus.wb_ready = 1'b0;
        model_clear();
        test_reset();
        test_read_hit();
        test_tag_miss();
        test_writeback();
        test_reset_mid_wb();
        test_priority();
        test_local_vs_snoop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
